// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage with in-order fetch buffer and PC freeze
module fetch_queue #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH:0]             pc_i,
    input  logic                       redirect_i,
    input  logic                       flush_i,
    output logic [WIDTH:0]             imem_addr_o,
    input  logic [WIDTH:0]             imem_data_i,
    output logic                       freeze_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH:0]             out_instr_o,
    output logic [WIDTH:0]             out_pc_o,
    output logic                       out_redirect_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Entry storage; contents are don't-care until written, so no reset
    logic [WIDTH:0] instr_mem [DEPTH];
    logic [WIDTH:0] pc_mem    [DEPTH];
    logic           redir_mem [DEPTH];

    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic           fetch_valid_q;
    logic [WIDTH:0] fetch_pc_q;
    logic           fetch_redirect_q;

    logic           issue;
    logic           push;
    logic           pop;
    logic [CW:0]    occupancy;

    // Memory is addressed straight from the PC register so the read lands next cycle
    assign imem_addr_o = pc_i;

    // Every in-flight fetch holds a reserved slot, so a push can never find the queue full
    assign occupancy   = {1'b0, count_q} + (CW+1)'(fetch_valid_q);
    assign freeze_o    = !flush_i && (occupancy >= (CW+1)'(DEPTH));

    assign issue       = !freeze_o && !flush_i;
    assign out_valid_o = (count_q != '0);
    assign push        = fetch_valid_q && !flush_i;
    assign pop         = out_valid_o && out_ready_i && !flush_i;

    assign out_instr_o    = instr_mem[head_q];
    assign out_pc_o       = pc_mem[head_q];
    assign out_redirect_o = redir_mem[head_q];
    assign count_o        = count_q;

    // Next-state for occupancy and pointers; flush discards everything
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (push) tail_d = tail_q + AW'(1);
            if (pop)  head_d = head_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue control state and the one-deep in-flight fetch record
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q          <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            fetch_valid_q    <= 1'b0;
            fetch_pc_q       <= '0;
            fetch_redirect_q <= 1'b0;
        end else begin
            count_q          <= count_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            fetch_valid_q    <= issue;
            fetch_pc_q       <= pc_i;
            fetch_redirect_q <= redirect_i;
        end
    end

    // Returning instruction is bundled with the PC and redirect bit that fetched it
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= imem_data_i;
            pc_mem[tail_q]    <= fetch_pc_q;
            redir_mem[tail_q] <= fetch_redirect_q;
        end
    end

    // Structural invariants of the reservation scheme
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(push && (count_q == CW'(DEPTH))));
            assert (!(pop && (count_q == '0)));
            assert (count_q <= CW'(DEPTH));
        end
    end

endmodule
